// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: EX-stage operand forwarding, load-use stall and a
// multi-cycle multiply/divide stall sequencer.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       branchTakenD,
    input  logic       jumpD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeRegE,
    input  logic       Regfile_weE,
    input  logic       memToRegE,
    input  logic       mdStartE,
    input  logic       mdDivE,
    input  logic [4:0] writeRegM,
    input  logic       Regfile_weM,
    input  logic [4:0] writeRegW,
    input  logic       Regfile_weW,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic [1:0] fwdAE,
    output logic [1:0] fwdBE,
    output logic       mdBusy,
    output logic       mdDone
);

    typedef enum logic [1:0] {StIdle, StBusy, StLast} md_state_e;

    md_state_e  state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       md_stall;
    logic       load_use;
    logic [1:0] fwd_a, fwd_b;

    // MEM result wins over WB; r0 is hard-wired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       we_m,
                                           input logic [4:0] reg_m,
                                           input logic       we_w,
                                           input logic [4:0] reg_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (we_m && (reg_m != 5'd0) && (reg_m == src)) begin
            sel = 2'b10;
        end else if (we_w && (reg_w != 5'd0) && (reg_w == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mdStartE) begin
                    state_d = StBusy;
                    cnt_d   = mdDivE ? 5'd30 : 5'd2;
                end
            end
            StBusy: begin
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    state_d = StLast;
                end
            end
            // mdStartE is still high for the finishing instruction; ignore it here.
            StLast: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        md_stall = ((state_q == StIdle) && mdStartE) || (state_q == StBusy);
        load_use = memToRegE && Regfile_weE && (writeRegE != 5'd0) &&
                   ((writeRegE == rsD) || (writeRegE == rtD));
        fwd_a    = fwd_sel(rsE, Regfile_weM, writeRegM, Regfile_weW, writeRegW);
        fwd_b    = fwd_sel(rtE, Regfile_weM, writeRegM, Regfile_weW, writeRegW);
    end

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        fwdAE  = 2'b00;
        fwdBE  = 2'b00;
        mdBusy = 1'b0;
        mdDone = 1'b0;
        if (rst) begin
            stallF = md_stall | load_use;
            stallD = md_stall | load_use;
            stallE = md_stall;
            // A held fetch must not also lose its instruction to a redirect.
            flushD = (branchTakenD | jumpD) & ~(md_stall | load_use);
            flushE = load_use & ~md_stall;
            flushM = md_stall;
            fwdAE  = fwd_a;
            fwdBE  = fwd_b;
            mdBusy = (state_q == StBusy) || (state_q == StLast);
            mdDone = (state_q == StLast);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected output vectors are queued as each
// stimulus step is driven and checked half a cycle later.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic       branchTakenD, jumpD, Regfile_weE, memToRegE, mdStartE, mdDivE;
    logic       Regfile_weM, Regfile_weW;
    logic       stallF, stallD, stallE, flushD, flushE, flushM, mdBusy, mdDone;
    logic [1:0] fwdAE, fwdBE;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [13:0] exp_q[$];
    string       tag_q[$];

    // Reference model: stall cycles still owed after this one, and done flag.
    int m_rem  = 0;
    bit m_done = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchTakenD(branchTakenD),
        .jumpD(jumpD), .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE),
        .Regfile_weE(Regfile_weE), .memToRegE(memToRegE), .mdStartE(mdStartE),
        .mdDivE(mdDivE), .writeRegM(writeRegM), .Regfile_weM(Regfile_weM),
        .writeRegW(writeRegW), .Regfile_weW(Regfile_weW), .stallF(stallF),
        .stallD(stallD), .stallE(stallE), .flushD(flushD), .flushE(flushE),
        .flushM(flushM), .fwdAE(fwdAE), .fwdBE(fwdBE), .mdBusy(mdBusy), .mdDone(mdDone)
    );

    function automatic logic [1:0] ref_fwd(input logic [4:0] r);
        if (Regfile_weM && writeRegM != 0 && writeRegM == r) return 2'b10;
        if (Regfile_weW && writeRegW != 0 && writeRegW == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [13:0] expect_vec();
        logic stl, lu, idle, sf, fd, fe, busy;
        idle = (m_rem == 0) && !m_done;
        stl  = (m_rem > 0) || (idle && mdStartE);
        lu   = memToRegE && Regfile_weE && writeRegE != 0 &&
               (writeRegE == rsD || writeRegE == rtD);
        sf   = stl | lu;
        fd   = (branchTakenD | jumpD) & ~sf;
        fe   = lu & ~stl;
        busy = (m_rem > 0) || m_done;
        if (!rst) return 14'd0;
        return {sf, sf, stl, fd, fe, stl, ref_fwd(rsE), ref_fwd(rtE), busy, m_done};
    endfunction

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeRegE = 0; writeRegM = 0; writeRegW = 0;
        branchTakenD = 0; jumpD = 0; Regfile_weE = 0; memToRegE = 0; mdStartE = 0;
        mdDivE = 0; Regfile_weM = 0; Regfile_weW = 0;
    endtask

    task automatic step(input string tag);
        logic [13:0] got, exp;
        string       t;
        exp_q.push_back(expect_vec());
        tag_q.push_back(tag);
        @(negedge clk);
        got = {stallF, stallD, stallE, flushD, flushE, flushM, fwdAE, fwdBE, mdBusy, mdDone};
        exp = exp_q.pop_front();
        t   = tag_q.pop_front();
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%b exp=%b (sF sD sE fD fE fM fA fB busy done)", t, got, exp);
        end
        @(posedge clk);
        if (!rst) begin
            m_rem = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_done = 1;
        end else if (mdStartE) begin
            m_rem = mdDivE ? 31 : 3;
        end
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        // Busy inputs during reset must still yield all-zero outputs.
        writeRegM = 5; Regfile_weM = 1; rsE = 5; rtE = 5;
        memToRegE = 1; Regfile_weE = 1; writeRegE = 8; rtD = 8; branchTakenD = 1;
        step("reset_outputs_zero");
        step("reset_outputs_zero_2");
        clear_inputs();
        rst = 1;
        step("idle_after_reset");

        writeRegM = 5; Regfile_weM = 1; writeRegW = 5; Regfile_weW = 1; rsE = 5;
        step("fwdA_mem_priority");
        Regfile_weM = 0;
        step("fwdA_wb");
        writeRegM = 0; Regfile_weM = 1; rtE = 0; writeRegW = 0;
        step("fwdB_r0_never");
        writeRegM = 3; writeRegW = 7; rsE = 7; rtE = 3;
        step("fwd_split_a_wb_b_mem");
        Regfile_weM = 0; Regfile_weW = 0;
        step("fwd_no_enables");

        clear_inputs();
        memToRegE = 1; Regfile_weE = 1; writeRegE = 8; rtD = 8;
        step("load_use_rt");
        memToRegE = 0;
        step("after_load_use_no_stall");
        memToRegE = 1; rtD = 0; rsD = 8; jumpD = 1;
        step("load_use_rs_suppresses_jump");
        writeRegE = 0; rsD = 0;
        step("load_r0_no_stall_jump_flush");
        clear_inputs();
        branchTakenD = 1;
        step("branch_flushD");

        clear_inputs();
        mdStartE = 1; mdDivE = 0;
        for (int i = 0; i < 5; i++) step($sformatf("mul_cycle_%0d", i));
        mdStartE = 0;
        step("mul_idle_after");

        mdStartE = 1; mdDivE = 1;
        for (int i = 0; i < 33; i++) begin
            branchTakenD = (i == 5);
            memToRegE = (i == 6); Regfile_weE = (i == 6); writeRegE = 9; rsD = 9;
            step($sformatf("div_cycle_%0d", i));
        end
        memToRegE = 0; Regfile_weE = 0; branchTakenD = 0;
        mdDivE = 0;
        for (int i = 0; i < 5; i++) step($sformatf("mul_b2b_cycle_%0d", i));
        mdStartE = 0;
        step("b2b_idle_after");

        mdStartE = 1; mdDivE = 1;
        for (int i = 0; i < 10; i++) step($sformatf("div_pre_reset_%0d", i));
        rst = 0;
        step("reset_mid_div");
        rst = 1; mdStartE = 0;
        for (int i = 0; i < 4; i++) step($sformatf("post_reset_idle_%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
